// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for a multi-cycle RV32I datapath in which instruction
// fetch and load/store share one memory port. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The controller emits per-state
// strobes for the datapath. It also tolerates variable-latency memory
// through a req/ready handshake. A wait watchdog traps a stuck bus, and
// unknown opcodes trap as illegal.
//
// Parameters
//   WAIT_LIMIT   max cycles mem_req may go unacknowledged (0 = no watchdog)
//   WCNT_W       width of the wait counter, WAIT_LIMIT < 2**WCNT_W
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   opcode[6:0]  in   IR[6:0], stable from DECODE until the next FETCH
//   funct3[2:0]  in   IR[14:12], passed through as mem_size during MEM
//   branch_cond  in   datapath comparator result, valid in EXEC
//   mem_ready    in   memory acknowledge, completes access with mem_req
//   mem_req      out  memory access request
//   mem_we       out  1 = store, 0 = read
//   mem_addr_sel out  0 = PC, 1 = ALU result register
//   mem_size     out  funct3 in MEM, 3'b010 (word) in FETCH
//   ir_write     out  latch fetched word into IR and PC into old_pc
//   pc_write     out  update PC
//   pc_src       out  00 = PC+4, 01 = ALU result, 10 = ALU result & ~1
//   alu_src_a    out  00 = rs1, 01 = old_pc, 10 = zero
//   alu_src_b    out  0 = rs2, 1 = immediate
//   alu_op       out  00 = add, 01 = sub/compare, 10 = funct-decoded
//   result_sel   out  00 = ALU register, 01 = memory data, 10 = old_pc+4
//   reg_write    out  register file write enable
//   retire       out  one-cycle pulse on the last cycle of an instruction
//   trap         out  sticky: illegal opcode or bus error
//   bus_error    out  sticky: watchdog expired
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int WAIT_LIMIT = 255,
    parameter int WCNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_cond,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic [2:0] mem_size,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_sel,
    output logic       reg_write,
    output logic       retire,
    output logic       trap,
    output logic       bus_error
);

    // FSM state encoding
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    // RV32I base opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Watchdog fires when the counter has already counted WAIT_LIMIT-1
    // stalled cycles and this cycle is stalled too.
    localparam bit              WD_EN     = (WAIT_LIMIT != 0);
    localparam logic [WCNT_W-1:0] WAIT_LAST =
        WCNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [WCNT_W-1:0] wait_cnt;
    logic              trap_q;
    logic              bus_error_q;

    logic is_r, is_i, is_load, is_store, is_branch;
    logic is_jal, is_jalr, is_lui, is_auipc, is_legal;
    logic mem_phase;
    logic stalled;
    logic wd_fire;

    // Opcode classification, shared by DECODE, EXEC, MEM and WB.
    always_comb begin
        is_r      = (opcode == OP_R);
        is_i      = (opcode == OP_I);
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_branch = (opcode == OP_BRANCH);
        is_jal    = (opcode == OP_JAL);
        is_jalr   = (opcode == OP_JALR);
        is_lui    = (opcode == OP_LUI);
        is_auipc  = (opcode == OP_AUIPC);
        is_legal  = is_r | is_i | is_load | is_store | is_branch |
                    is_jal | is_jalr | is_lui | is_auipc;
    end

    // mem_req is high exactly in FETCH and MEM. The watchdog is derived from
    // the state directly, not from mem_req, so the output decode block does
    // not feed back into itself.
    assign mem_phase = (state == S_FETCH) || (state == S_MEM);
    assign stalled   = mem_phase && !mem_ready;
    assign wd_fire   = WD_EN && stalled && (wait_cnt == WAIT_LAST);

    // Output strobes and next-state decode. Every strobe defaults to 0, and
    // each state raises only what it needs. A mem_ready on the watchdog edge
    // is checked first, so a late acknowledge still completes the access.
    always_comb begin
        next_state   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        mem_size     = 3'b000;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 1'b0;
        alu_op       = 2'b00;
        result_sel   = 2'b00;
        reg_write    = 1'b0;
        retire       = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_size = 3'b010;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (wd_fire) begin
                    next_state = S_TRAP;
                end
            end

            // The ALU computes old_pc + imm speculatively here. A branch
            // then finds its target waiting in the ALU register.
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 1'b1;
                next_state = is_legal ? S_EXEC : S_TRAP;
            end

            S_EXEC: begin
                if (is_r) begin
                    alu_op     = 2'b10;
                    next_state = S_WB;
                end else if (is_i) begin
                    alu_src_b  = 1'b1;
                    alu_op     = 2'b10;
                    next_state = S_WB;
                end else if (is_load || is_store) begin
                    alu_src_b  = 1'b1;
                    next_state = S_MEM;
                end else if (is_branch) begin
                    alu_op     = 2'b01;
                    pc_write   = branch_cond;
                    pc_src     = 2'b01;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (is_jal) begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = 2'b01;
                    next_state = S_WB;
                end else if (is_jalr) begin
                    alu_src_b  = 1'b1;
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    next_state = S_WB;
                end else if (is_lui) begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 1'b1;
                    next_state = S_WB;
                end else if (is_auipc) begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 1'b1;
                    next_state = S_WB;
                end else begin
                    // Only reachable if the opcode changed after DECODE.
                    next_state = S_TRAP;
                end
            end

            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                mem_size     = funct3;
                if (mem_ready) begin
                    if (is_store) begin
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (wd_fire) begin
                    next_state = S_TRAP;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
                if (is_load) begin
                    result_sel = 2'b01;
                end else if (is_jal || is_jalr) begin
                    result_sel = 2'b10;
                end
            end

            S_TRAP: begin
                next_state = S_TRAP;
            end

            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // State register and sticky flags. TRAP can only be left through rst,
    // so trap simply records that TRAP has been entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            trap_q      <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state       <= next_state;
            trap_q      <= trap_q | (next_state == S_TRAP);
            bus_error_q <= bus_error_q | wd_fire;
        end
    end

    // Wait counter: counts consecutive unacknowledged request cycles and
    // clears whenever the bus is idle or an access completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (stalled) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign trap      = trap_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller with WAIT_LIMIT = 4. The stimulus
// process drives one cycle at a time and queues the hand-derived output
// vector expected during that cycle. A separate monitor pops and compares on
// every falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic [2:0] mem_size;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_sel;
        logic       reg_write;
        logic       retire;
        logic       trap;
        logic       bus_error;
    } outs_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_cond;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel;
    logic [2:0] mem_size;
    logic       ir_write, pc_write;
    logic [1:0] pc_src, alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op, result_sel;
    logic       reg_write, retire, trap, bus_error;

    outs_t dut_out;
    outs_t exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    fails  = 0;

    multicycle_controller #(.WAIT_LIMIT(4), .WCNT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .branch_cond(branch_cond), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .mem_size(mem_size), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_sel(result_sel), .reg_write(reg_write),
        .retire(retire), .trap(trap), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    assign dut_out = {mem_req, mem_we, mem_addr_sel, mem_size, ir_write,
                      pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
                      result_sel, reg_write, retire, trap, bus_error};

    // Expected-vector builders, one per controller state.
    function automatic outs_t o_fetch(input logic rdy);
        outs_t o = '0;
        o.mem_req  = 1'b1;
        o.mem_size = 3'b010;
        o.ir_write = rdy;
        o.pc_write = rdy;
        return o;
    endfunction

    function automatic outs_t o_decode();
        outs_t o = '0;
        o.alu_src_a = 2'b01;
        o.alu_src_b = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_exec(input logic [1:0] a, input logic b,
                                     input logic [1:0] op, input logic pw,
                                     input logic [1:0] ps, input logic ret);
        outs_t o = '0;
        o.alu_src_a = a;
        o.alu_src_b = b;
        o.alu_op    = op;
        o.pc_write  = pw;
        o.pc_src    = ps;
        o.retire    = ret;
        return o;
    endfunction

    function automatic outs_t o_mem(input logic we, input logic [2:0] sz,
                                    input logic rdy);
        outs_t o = '0;
        o.mem_req      = 1'b1;
        o.mem_addr_sel = 1'b1;
        o.mem_we       = we;
        o.mem_size     = sz;
        o.retire       = we & rdy;
        return o;
    endfunction

    function automatic outs_t o_wb(input logic [1:0] rs);
        outs_t o = '0;
        o.reg_write  = 1'b1;
        o.retire     = 1'b1;
        o.result_sel = rs;
        return o;
    endfunction

    function automatic outs_t o_trap(input logic be);
        outs_t o = '0;
        o.trap      = 1'b1;
        o.bus_error = be;
        return o;
    endfunction

    // Drive one cycle of inputs, queue what the outputs must be during that
    // cycle, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic r, input logic [6:0] opc,
                                 input logic [2:0] f3, input logic bc,
                                 input logic rdy, input outs_t e,
                                 input string nm);
        rst         = r;
        opcode      = opc;
        funct3      = f3;
        branch_cond = bc;
        mem_ready   = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string nm, input outs_t e);
        checks++;
        if (dut_out !== e) begin
            fails++;
            $display("[TB] FAIL %s: got %06h expected %06h (t=%0t)",
                     nm, dut_out, e, $time);
        end
    endtask

    // Zero-wait instruction that ends in WB: F, D, E, WB.
    task automatic runToWb(input logic [6:0] opc, input outs_t ex,
                           input logic [1:0] rs, input string nm);
        applyStimulus(1'b0, opc, 3'b000, 1'b0, 1'b1, o_fetch(1'b1), {nm, "_fetch"});
        applyStimulus(1'b0, opc, 3'b000, 1'b0, 1'b1, o_decode(), {nm, "_decode"});
        applyStimulus(1'b0, opc, 3'b000, 1'b0, 1'b1, ex, {nm, "_exec"});
        applyStimulus(1'b0, opc, 3'b000, 1'b0, 1'b1, o_wb(rs), {nm, "_wb"});
    endtask

    // Monitor: compare whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(name_q.pop_front(), exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0; branch_cond = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        // Second reset cycle: state is already FETCH.
        applyStimulus(1'b1, 7'd0, 3'b000, 1'b0, 1'b0, o_fetch(1'b0), "reset_fetch");

        // R-type, memory tied ready.
        runToWb(OP_R, o_exec(2'b00, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0), 2'b00, "r");

        // LOAD (LBU) with three wait cycles in MEM.
        applyStimulus(1'b0, OP_LOAD, 3'b100, 1'b0, 1'b1, o_fetch(1'b1), "ld_fetch");
        applyStimulus(1'b0, OP_LOAD, 3'b100, 1'b0, 1'b0, o_decode(), "ld_decode");
        applyStimulus(1'b0, OP_LOAD, 3'b100, 1'b0, 1'b0,
                      o_exec(2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0), "ld_exec");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, OP_LOAD, 3'b100, 1'b0, 1'b0, o_mem(1'b0, 3'b100, 1'b0), "ld_mem_wait");
        applyStimulus(1'b0, OP_LOAD, 3'b100, 1'b0, 1'b1, o_mem(1'b0, 3'b100, 1'b1), "ld_mem_done");
        applyStimulus(1'b0, OP_LOAD, 3'b100, 1'b0, 1'b0, o_wb(2'b01), "ld_wb");

        // Branch taken, then not taken.
        applyStimulus(1'b0, OP_BRANCH, 3'b000, 1'b1, 1'b1, o_fetch(1'b1), "bt_fetch");
        applyStimulus(1'b0, OP_BRANCH, 3'b000, 1'b1, 1'b1, o_decode(), "bt_decode");
        applyStimulus(1'b0, OP_BRANCH, 3'b000, 1'b1, 1'b1,
                      o_exec(2'b00, 1'b0, 2'b01, 1'b1, 2'b01, 1'b1), "bt_exec");
        applyStimulus(1'b0, OP_BRANCH, 3'b000, 1'b0, 1'b1, o_fetch(1'b1), "bn_fetch");
        applyStimulus(1'b0, OP_BRANCH, 3'b000, 1'b0, 1'b1, o_decode(), "bn_decode");
        applyStimulus(1'b0, OP_BRANCH, 3'b000, 1'b0, 1'b1,
                      o_exec(2'b00, 1'b0, 2'b01, 1'b0, 2'b01, 1'b1), "bn_exec");

        // Jumps and the remaining ALU-class instructions.
        runToWb(OP_JALR,  o_exec(2'b00, 1'b1, 2'b00, 1'b1, 2'b10, 1'b0), 2'b10, "jalr");
        runToWb(OP_JAL,   o_exec(2'b01, 1'b1, 2'b00, 1'b1, 2'b01, 1'b0), 2'b10, "jal");
        runToWb(OP_I,     o_exec(2'b00, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0), 2'b00, "itype");
        runToWb(OP_LUI,   o_exec(2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0), 2'b00, "lui");
        runToWb(OP_AUIPC, o_exec(2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0), 2'b00, "auipc");

        // STORE (SH), zero-wait: retires in MEM after four cycles.
        applyStimulus(1'b0, OP_STORE, 3'b001, 1'b0, 1'b1, o_fetch(1'b1), "st_fetch");
        applyStimulus(1'b0, OP_STORE, 3'b001, 1'b0, 1'b1, o_decode(), "st_decode");
        applyStimulus(1'b0, OP_STORE, 3'b001, 1'b0, 1'b1,
                      o_exec(2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0), "st_exec");
        applyStimulus(1'b0, OP_STORE, 3'b001, 1'b0, 1'b1, o_mem(1'b1, 3'b001, 1'b1), "st_mem");

        // Illegal opcode: TRAP for good, mem_ready toggling is ignored.
        applyStimulus(1'b0, OP_BAD, 3'b000, 1'b0, 1'b1, o_fetch(1'b1), "ill_fetch");
        applyStimulus(1'b0, OP_BAD, 3'b000, 1'b0, 1'b0, o_decode(), "ill_decode");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, OP_BAD, 3'b000, 1'b0, logic'(i[0]), o_trap(1'b0), "ill_trap");
        applyStimulus(1'b1, OP_BAD, 3'b000, 1'b0, 1'b0, o_trap(1'b0), "ill_rst");

        // Watchdog: four unacknowledged FETCH cycles then bus-error trap.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, OP_R, 3'b000, 1'b0, 1'b0, o_fetch(1'b0), "wd_wait");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, OP_R, 3'b000, 1'b0, 1'b0, o_trap(1'b1), "wd_trap");
        applyStimulus(1'b1, OP_R, 3'b000, 1'b0, 1'b0, o_trap(1'b1), "wd_rst");

        // Acknowledge on the last allowed wait cycle wins over the watchdog.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, OP_R, 3'b000, 1'b0, 1'b0, o_fetch(1'b0), "wd2_wait");
        applyStimulus(1'b0, OP_R, 3'b000, 1'b0, 1'b1, o_fetch(1'b1), "wd2_ack");
        applyStimulus(1'b0, OP_R, 3'b000, 1'b0, 1'b0, o_decode(), "wd2_decode");
        applyStimulus(1'b0, OP_R, 3'b000, 1'b0, 1'b0,
                      o_exec(2'b00, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0), "wd2_exec");
        applyStimulus(1'b0, OP_R, 3'b000, 1'b0, 1'b0, o_wb(2'b00), "wd2_wb");
        applyStimulus(1'b0, OP_R, 3'b000, 1'b0, 1'b0, o_fetch(1'b0), "wd2_next_fetch");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
